// File: rtl/priRV32_pkg.sv
// priRV32_pkg: shared core width, default reset vector and PC step
package priRV32_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  localparam int ENTRY_W = 2 * XLEN;
endpackage

// File: rtl/cpu_fetch_fifo.sv
// cpu_fetch_fifo: two-entry {pc, inst} buffer with flush and same-cycle push/pop
module cpu_fetch_fifo
  import priRV32_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [1:0]         count,
  output logic [ENTRY_W-1:0] head
);
  logic [ENTRY_W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0] count_q, count_d;
  logic do_pop, do_push, wr_slot;
  assign do_pop = pop && count_q != 2'd0;
  assign do_push = push && (count_q != 2'd2 || do_pop);
  assign wr_slot = (count_q - {1'b0, do_pop}) != 2'd0;
  assign count = count_q;
  assign head = e0_q;
  // shift on pop, write into the first free slot left after the pop
  always_comb begin
    e0_d = do_pop ? e1_q : e0_q;
    e1_d = e1_q;
    if (do_push && !wr_slot) e0_d = push_data;
    if (do_push && wr_slot) e1_d = push_data;
    count_d = flush ? 2'd0 : count_q + {1'b0, do_push} - {1'b0, do_pop};
  end
  // entry and occupancy registers
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      e0_q <= '0;
      e1_q <= '0;
      count_q <= '0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      count_q <= count_d;
    end
endmodule

// File: rtl/cpu_fetch.sv
// cpu_fetch: credit-limited instruction fetch with redirect flush and response dropping
module cpu_fetch
  import priRV32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk_in,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc
);
  logic [XLEN-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, target;
  logic [1:0] in_flight_q, in_flight_d, drop_q, drop_d, count;
  logic [ENTRY_W-1:0] head;
  logic accept, push, pop;
  assign target = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
  assign imem_req_valid = rst_n && !redirect_valid && (({1'b0, in_flight_q} + {1'b0, count}) < 3'(FIFO_DEPTH));
  assign imem_req_addr = pc_q;
  assign accept = imem_req_valid && imem_req_ready;
  assign push = imem_rsp_valid && drop_q == 2'd0 && !redirect_valid;
  assign pop = inst_ready && !redirect_valid;
  assign inst_valid = count != 2'd0;
  assign {inst_pc, inst_data} = head;
  // rsp_pc tracks the address of the next kept response, so no per-request PC queue is needed
  always_comb begin
    pc_d = redirect_valid ? target : accept ? pc_q + PC_INC : pc_q;
    in_flight_d = in_flight_q + {1'b0, accept} - {1'b0, imem_rsp_valid};
    drop_d = redirect_valid ? in_flight_d : (imem_rsp_valid && drop_q != 2'd0) ? drop_q - 2'd1 : drop_q;
    rsp_pc_d = redirect_valid ? target : push ? rsp_pc_q + PC_INC : rsp_pc_q;
  end
  // fetch state registers
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      in_flight_q <= '0;
      drop_q <= '0;
    end else begin
      pc_q <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      in_flight_q <= in_flight_d;
      drop_q <= drop_d;
    end
  cpu_fetch_fifo u_fifo (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({rsp_pc_q, imem_rsp_data}),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );
endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch: directed scenarios with an expected-PC scoreboard for the fetch unit
module tb_cpu_fetch;
  localparam logic [31:0] K = 32'hA5A5_0F0F;
  logic clk_in = 0;
  logic rst_n = 0;
  logic imem_req_valid, imem_rsp_valid, inst_valid;
  logic imem_req_ready = 1;
  logic inst_ready = 1;
  logic redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic [31:0] imem_req_addr, imem_rsp_data, inst_data, inst_pc;
  logic w_req_valid, w_inst_valid;
  logic [31:0] w_req_addr, w_inst_data, w_inst_pc;
  logic comb_mem = 1;
  logic mem_go = 0;
  logic acc;
  logic [31:0] p0, p1, mon_exp;
  int np = 0;
  logic [31:0] exp_pc[$];
  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  cpu_fetch dut (
    .clk_in(clk_in), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
  );

  cpu_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk_in(clk_in), .rst_n(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_req_valid), .imem_rsp_data(w_req_addr ^ K),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_valid(w_inst_valid), .inst_ready(1'b1), .inst_data(w_inst_data), .inst_pc(w_inst_pc)
  );

  // memory: combinational (same-cycle) or queued with responses released by mem_go
  assign acc = imem_req_valid && imem_req_ready;
  assign imem_rsp_valid = comb_mem ? acc : (mem_go && np != 0);
  assign imem_rsp_data = (comb_mem ? imem_req_addr : p0) ^ K;
  always @(posedge clk_in)
    if (!rst_n) np <= 0;
    else if (!comb_mem) begin
      if (imem_rsp_valid) p0 <= p1;
      if (acc && np - int'(imem_rsp_valid) == 0) p0 <= imem_req_addr;
      if (acc && np - int'(imem_rsp_valid) != 0) p1 <= imem_req_addr;
      np <= np + int'(acc) - int'(imem_rsp_valid);
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_in);
    #1 rst_n = 0;
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1;
  endtask

  // scoreboard: every consumed instruction must be the next expected PC with its word
  initial forever begin
    @(negedge clk_in);
    if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
      if (exp_pc.size() != 0) mon_exp = exp_pc.pop_front();
      else mon_exp = 32'hDEAD_BEEF;
      checks += 2;
      assert (inst_pc === mon_exp) else begin
        errors++;
        $error("FAIL sb inst_pc: got %h expected %h", inst_pc, mon_exp);
      end
      assert (inst_data === (mon_exp ^ K)) else begin
        errors++;
        $error("FAIL sb inst_data: got %h expected %h", inst_data, mon_exp ^ K);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 5; i++) exp_pc.push_back(32'(4 * i));
    #2;
    chk("rst req_valid", imem_req_valid, 0);
    chk("rst inst_valid", inst_valid, 0);
    chk("rst inst_data", inst_data, 0);
    chk("rst inst_pc", inst_pc, 0);
    chk("rst req_addr", imem_req_addr, 0);
    chk("rst wrap req_valid", w_req_valid, 0);
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("s1 req_valid", imem_req_valid, 1);
      chk("s1 req_addr", imem_req_addr, 32'(4 * i));
      chk("s1 inst_valid", inst_valid, i != 0);
      if (i < 3) chk("wrap req_addr", w_req_addr, 32'hFFFF_FFF8 + 32'(4 * i));
      @(posedge clk_in);
      #1;
    end
    imem_req_ready = 0;
    #1 chk("s1 hold valid", imem_req_valid, 1);
    chk("s1 hold addr", imem_req_addr, 32'h14);
    @(posedge clk_in);
    #2 chk("s1 hold addr2", imem_req_addr, 32'h14);
    repeat (2) @(posedge clk_in);
    #1 chk("s1 drained", exp_pc.size(), 0);
    chk("s1 empty", inst_valid, 0);

    inst_ready = 0;
    imem_req_ready = 1;
    do_reset();
    #1 chk("s2 addr0", imem_req_addr, 0);
    chk("s2 valid0", imem_req_valid, 1);
    @(posedge clk_in);
    #2 chk("s2 addr1", imem_req_addr, 4);
    chk("s2 valid1", imem_req_valid, 1);
    @(posedge clk_in);
    #2 chk("s2 stall valid", imem_req_valid, 0);
    @(posedge clk_in);
    #2 chk("s2 stall valid2", imem_req_valid, 0);
    chk("s2 inst_valid", inst_valid, 1);
    chk("s2 head pc", inst_pc, 0);
    exp_pc.push_back(0);
    exp_pc.push_back(4);
    @(posedge clk_in);
    #1 inst_ready = 1;
    imem_req_ready = 0;
    repeat (3) @(posedge clk_in);
    #1 chk("s2 drained", exp_pc.size(), 0);

    comb_mem = 0;
    mem_go = 0;
    imem_req_ready = 1;
    do_reset();
    #1 chk("s3 addr0", imem_req_addr, 0);
    @(posedge clk_in);
    #2 chk("s3 addr1", imem_req_addr, 4);
    chk("s3 valid1", imem_req_valid, 1);
    @(posedge clk_in);
    #1 redirect_valid = 1;
    redirect_pc = 32'h103;
    #1 chk("s3 redirect req_valid", imem_req_valid, 0);
    @(posedge clk_in);
    #1 redirect_valid = 0;
    mem_go = 1;
    #1 chk("s3 busy req_valid", imem_req_valid, 0);
    chk("s3 no inst", inst_valid, 0);
    @(posedge clk_in);
    #1 exp_pc.push_back(32'h100);
    #1 chk("s3 new valid", imem_req_valid, 1);
    chk("s3 new addr", imem_req_addr, 32'h100);
    chk("s3 dropped", inst_valid, 0);
    @(posedge clk_in);
    #1 imem_req_ready = 0;
    repeat (3) @(posedge clk_in);
    #1 chk("s3 drained", exp_pc.size(), 0);

    imem_req_ready = 1;
    do_reset();
    @(posedge clk_in);
    @(posedge clk_in);
    #1 redirect_valid = 1;
    redirect_pc = 32'h200;
    #1 chk("s4 rsp valid", imem_rsp_valid, 1);
    chk("s4 inst_valid", inst_valid, 1);
    chk("s4 inst_pc", inst_pc, 0);
    chk("s4 redirect req_valid", imem_req_valid, 0);
    @(posedge clk_in);
    #1 redirect_valid = 0;
    imem_req_ready = 0;
    #1 chk("s4 flushed", inst_valid, 0);
    chk("s4 valid", imem_req_valid, 1);
    chk("s4 addr", imem_req_addr, 32'h200);
    redirect_valid = 1;
    redirect_pc = 32'h301;
    #1 chk("s4 suppress", imem_req_valid, 0);
    @(posedge clk_in);
    #1 redirect_valid = 0;
    #1 chk("s4 addr2", imem_req_addr, 32'h300);
    chk("s4 valid2", imem_req_valid, 1);
    repeat (2) @(posedge clk_in);
    #1 chk("s4 still empty", inst_valid, 0);
    mem_go = 0;
    comb_mem = 1;

    inst_ready = 0;
    imem_req_ready = 1;
    do_reset();
    repeat (2) @(posedge clk_in);
    #2 chk("s5 full", inst_valid, 1);
    chk("s5 full req_valid", imem_req_valid, 0);
    rst_n = 0;
    #1 chk("s5 rst inst_valid", inst_valid, 0);
    chk("s5 rst req_valid", imem_req_valid, 0);
    chk("s5 rst inst_pc", inst_pc, 0);
    chk("s5 rst inst_data", inst_data, 0);
    exp_pc.push_back(0);
    inst_ready = 1;
    @(posedge clk_in);
    #1 rst_n = 1;
    #1 chk("s5 restart valid", imem_req_valid, 1);
    chk("s5 restart addr", imem_req_addr, 0);
    @(posedge clk_in);
    #1 imem_req_ready = 0;
    repeat (3) @(posedge clk_in);
    #1 chk("s5 drained", exp_pc.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
